// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus of the PC generator: hazard controller inputs, the I-cache
// valid strobe, and the fetch address / redirect status driven back out.
interface fetch_pc_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  stall;
  logic                  load_pc_we;
  logic [ADDR_WIDTH-1:0] load_pc_new_pc;
  logic                  ic_valid;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  redirect_pending;

  // Hazard controller / I-cache side
  modport master (
    output stall,
    output load_pc_we,
    output load_pc_new_pc,
    output ic_valid,
    input  fetch_pc,
    input  redirect_pending
  );

  // PC generator side
  modport slave (
    input  stall,
    input  load_pc_we,
    input  load_pc_new_pc,
    input  ic_valid,
    output fetch_pc,
    output redirect_pending
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator. Sequences the fetch PC (+4 / redirect / hold),
// parks a redirect that arrives during a stall so it is never lost, and keeps
// saturating fetch, redirect and stall-cycle counters.
module fetch_pc_unit #(
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int                  CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_pc_unit_if.slave       bus,
  output logic [CNT_WIDTH-1:0] perf_fetched,
  output logic [CNT_WIDTH-1:0] perf_redirects,
  output logic [CNT_WIDTH-1:0] perf_stall_cycles
);

  typedef enum logic {RUN, PEND} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_pc, pend_d;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Next-state / next-PC selection; a fresh redirect always beats a parked one.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_pc;
    if (bus.load_pc_we && !bus.stall) begin
      pc_d    = bus.load_pc_new_pc;
      state_d = RUN;
    end else if (bus.load_pc_we && bus.stall) begin
      pend_d  = bus.load_pc_new_pc;
      state_d = PEND;
    end else if (!bus.stall && state_q == PEND) begin
      // The parked target is on fetch_pc now and is consumed this cycle.
      pc_d    = pend_pc + ADDR_WIDTH'(4);
      state_d = RUN;
    end else if (!bus.stall) begin
      pc_d    = pc_q + ADDR_WIDTH'(4);
    end
  end

  // PC, parked target and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_pc <= pend_d;
    end
  end

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched      <= '0;
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (!bus.stall && bus.ic_valid) perf_fetched <= sat_inc(perf_fetched);
      if (bus.load_pc_we)             perf_redirects <= sat_inc(perf_redirects);
      if (bus.stall)                  perf_stall_cycles <= sat_inc(perf_stall_cycles);
    end
  end

  // Muxing from registers only, so the I-cache sees a parked target at once
  // without any path from the live inputs.
  assign bus.fetch_pc         = (state_q == PEND) ? pend_pc : pc_q;
  assign bus.redirect_pending = (state_q == PEND);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a 32-bit-counter instance and a 4-bit-counter
// instance (different RESET_PC) driven in lockstep, checked against a model
// that tracks only the visible fetch address, a pending flag and event counts.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_s = 1'b1;
  logic        stall_s = 1'b0;
  logic        we_s = 1'b0;
  logic [31:0] tgt_s = '0;
  logic        iv_s = 1'b0;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit_if #(.ADDR_WIDTH(32)) bus_a ();
  fetch_pc_unit_if #(.ADDR_WIDTH(32)) bus_b ();

  assign bus_a.stall          = stall_s;
  assign bus_a.load_pc_we     = we_s;
  assign bus_a.load_pc_new_pc = tgt_s;
  assign bus_a.ic_valid       = iv_s;
  assign bus_b.stall          = stall_s;
  assign bus_b.load_pc_we     = we_s;
  assign bus_b.load_pc_new_pc = tgt_s;
  assign bus_b.ic_valid       = iv_s;

  logic [31:0] fet_a, red_a, stl_a;
  logic [3:0]  fet_b, red_b, stl_b;

  fetch_pc_unit #(.ADDR_WIDTH(32), .RESET_PC(RST_A), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst_s), .bus(bus_a),
    .perf_fetched(fet_a), .perf_redirects(red_a), .perf_stall_cycles(stl_a)
  );

  fetch_pc_unit #(.ADDR_WIDTH(32), .RESET_PC(RST_B), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst_s), .bus(bus_b),
    .perf_fetched(fet_b), .perf_redirects(red_b), .perf_stall_cycles(stl_b)
  );

  always #5 clk = ~clk;

  // Reference model: what fetch_pc shows, whether a redirect is parked, raw event counts.
  logic [31:0] m_fetch_a, m_fetch_b;
  logic        m_pend;
  longint      n_fet, n_red, n_stl;

  function automatic longint cap(input longint c, input longint m);
    return (c > m) ? m : c;
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic w,
                            input logic [31:0] t, input logic v);
    if (r) begin
      m_fetch_a = RST_A;
      m_fetch_b = RST_B;
      m_pend    = 1'b0;
      n_fet = 0; n_red = 0; n_stl = 0;
    end else begin
      if (!s && v) n_fet++;
      if (w)       n_red++;
      if (s)       n_stl++;
      if (w) begin
        m_fetch_a = t;
        m_fetch_b = t;
      end else if (!s) begin
        m_fetch_a = m_fetch_a + 32'd4;
        m_fetch_b = m_fetch_b + 32'd4;
      end
      m_pend = s && (w || m_pend);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/pc_a"},   bus_a.fetch_pc, m_fetch_a);
    chk({tag, "/pc_b"},   bus_b.fetch_pc, m_fetch_b);
    chk({tag, "/pend_a"}, {31'd0, bus_a.redirect_pending}, {31'd0, m_pend});
    chk({tag, "/pend_b"}, {31'd0, bus_b.redirect_pending}, {31'd0, m_pend});
    chk({tag, "/fet_a"},  fet_a, 32'(cap(n_fet, 64'hFFFF_FFFF)));
    chk({tag, "/red_a"},  red_a, 32'(cap(n_red, 64'hFFFF_FFFF)));
    chk({tag, "/stl_a"},  stl_a, 32'(cap(n_stl, 64'hFFFF_FFFF)));
    chk({tag, "/fet_b"},  {28'd0, fet_b}, 32'(cap(n_fet, 15)));
    chk({tag, "/red_b"},  {28'd0, red_b}, 32'(cap(n_red, 15)));
    chk({tag, "/stl_b"},  {28'd0, stl_b}, 32'(cap(n_stl, 15)));
  endtask

  // Drive one cycle's inputs, let the edge happen, then sample 1 ns later.
  task automatic step(input string tag, input logic r, input logic s, input logic w,
                      input logic [31:0] t, input logic v);
    rst_s = r; stall_s = s; we_s = w; tgt_s = t; iv_s = v;
    @(posedge clk);
    model_edge(r, s, w, t, v);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic r, s, w, v;
    logic [31:0] t;

    // Reset then free run
    step("reset", 1, 0, 0, 32'h0, 0);
    chk("reset_pc_lit", bus_a.fetch_pc, 32'h0);
    for (int i = 0; i < 4; i++) step("run", 0, 0, 0, 32'h0, 1);
    chk("run_pc_lit", bus_a.fetch_pc, 32'h10);
    chk("run_fetched_lit", fet_a, 32'd4);

    // Unstalled redirect
    step("redir", 0, 0, 1, 32'h100, 1);
    chk("redir_pc_lit", bus_a.fetch_pc, 32'h100);
    step("redir_next", 0, 0, 0, 32'h0, 1);
    chk("redir_next_lit", bus_a.fetch_pc, 32'h104);
    chk("redir_cnt_lit", red_a, 32'd1);

    // Redirect during stall, superseded by a later one
    step("st1", 0, 1, 1, 32'h200, 1);
    chk("st1_pend_lit", {31'd0, bus_a.redirect_pending}, 32'd1);
    chk("st1_pc_lit", bus_a.fetch_pc, 32'h200);
    step("st2", 0, 1, 0, 32'h0, 1);
    step("st3", 0, 1, 1, 32'h300, 1);
    chk("st3_pc_lit", bus_a.fetch_pc, 32'h300);
    step("st4", 0, 1, 0, 32'h0, 1);
    step("st5", 0, 1, 0, 32'h0, 1);
    chk("st5_pc_lit", bus_a.fetch_pc, 32'h300);
    step("unstall", 0, 0, 0, 32'h0, 1);
    chk("unstall_pc_lit", bus_a.fetch_pc, 32'h304);
    chk("unstall_red_lit", red_a, 32'd3);
    chk("unstall_stl_lit", stl_a, 32'd5);

    // Redirect on the unstall edge beats the parked target
    step("park", 0, 1, 1, 32'h200, 0);
    step("unst_redir", 0, 0, 1, 32'h400, 0);
    chk("unst_redir_pc_lit", bus_a.fetch_pc, 32'h400);
    chk("unst_redir_pend_lit", {31'd0, bus_a.redirect_pending}, 32'd0);

    // PC wrap
    step("wrap0", 0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap0_lit", bus_a.fetch_pc, 32'hFFFF_FFFC);
    step("wrap1", 0, 0, 0, 32'h0, 1);
    chk("wrap1_lit", bus_a.fetch_pc, 32'h0);

    // Long stall: the 4-bit counter sticks at 15
    for (int i = 0; i < 20; i++) step("sat", 0, 1, 0, 32'h0, 1);
    chk("sat_lit", {28'd0, stl_b}, 32'd15);

    // Reset while a redirect is parked
    step("pend500", 0, 1, 1, 32'h500, 0);
    step("rst_mid", 1, 1, 0, 32'h0, 1);
    chk("rst_mid_pc_lit", bus_a.fetch_pc, 32'h0);
    chk("rst_mid_pc_b_lit", bus_b.fetch_pc, RST_B);
    chk("rst_mid_pend_lit", {31'd0, bus_a.redirect_pending}, 32'd0);
    chk("rst_mid_red_lit", red_a, 32'd0);
    step("post_rst", 0, 0, 0, 32'h0, 1);
    chk("post_rst_lit", bus_a.fetch_pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 9) < 4);
      w = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step("rand", r, s, w, t, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
